// File: rtl/bitstream_uart_tx_pkg.sv
// bitstream_uart_tx_pkg
// Shared definitions for the bitstream UART transmitter slice:
//   - capture FSM encoding (WAIT_SYNC / COLLECT)
//   - byte serializer FSM encoding (IDLE / START / DATA / [PARITY] / STOP)
//   - frame geometry constants and the parity helper
// Configuration macro: EVEN_PARITY_EN adds the PARITY state (8E1 framing).
package bitstream_uart_tx_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int BYTES_PER_FRAME = 2;
  localparam int BYTE_BITS       = 8;
  localparam int IDX_W           = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef EVEN_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic {
    CAP_WAIT_SYNC = 1'b0,
    CAP_COLLECT   = 1'b1
  } cap_state_t;

  // Bit that makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [BYTE_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/bitstream_uart_tx_uart_tx_byte.sv
// uart_tx_byte
// Single-byte UART serializer, LSB first, DIV clocks per bit.
// A load accepted on the final clock of the stop bit chains straight into the
// next start bit, so back-to-back bytes have no idle gap.
// Ports:
//   clk_in  system clock
//   reset   asynchronous active-low reset
//   load    accept data (in IDLE, or on the last stop-bit clock)
//   data    byte to send
//   busy    serializer not idle
//   last    final clock of the stop bit
//   txd     serial line, idle high (registered)
// Configuration macro: EVEN_PARITY_EN inserts an even-parity bit after D7.
module uart_tx_byte
  import bitstream_uart_tx_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BYTE_BITS-1:0] data,
  output logic                 busy,
  output logic                 last,
  output logic                 txd
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  tx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     baud_reg, baud_next;
  logic [2:0]           bit_reg, bit_next;
  logic [BYTE_BITS-1:0] shift_reg, shift_next;
  logic                 txd_reg, txd_next;
  logic                 parity_reg, parity_next;
  logic                 bit_end;

  assign bit_end = (baud_reg == CNT_LAST);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg  <= TX_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      txd_reg    <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      txd_reg    <= txd_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    txd_next    = 1'b1;

    if (state_reg != TX_IDLE) begin
      baud_next = bit_end ? '0 : baud_reg + 1'b1;
    end

    case (state_reg)
      TX_IDLE: begin
        if (load) begin
          state_next  = TX_START;
          baud_next   = '0;
          shift_next  = data;
          parity_next = even_parity(data);
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_next = TX_DATA;
          bit_next   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == 3'd7) begin
`ifdef EVEN_PARITY_EN
            state_next = TX_PARITY;
`else
            state_next = TX_STOP;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
`ifdef EVEN_PARITY_EN
      TX_PARITY: begin
        if (bit_end) state_next = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          if (load) begin
            state_next  = TX_START;
            shift_next  = data;
            parity_next = even_parity(data);
          end else begin
            state_next = TX_IDLE;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase

    // Line level is registered from the next state so txd never glitches.
    case (state_next)
      TX_START:  txd_next = 1'b0;
      TX_DATA:   txd_next = shift_next[0];
`ifdef EVEN_PARITY_EN
      TX_PARITY: txd_next = parity_next;
`endif
      default:   txd_next = 1'b1;
    endcase
  end

  assign busy = (state_reg != TX_IDLE);
  assign last = (state_reg == TX_STOP) && bit_end;
  assign txd  = txd_reg;

endmodule

// File: rtl/bitstream_uart_tx.sv
// bitstream_uart_tx
// Rebuilds 16-bit frames from the select stage's serial output and sends each
// one as two UART bytes: bits [7:0] first, then [15:8], each LSB first.
// Ports:
//   clk_in       system clock
//   reset        asynchronous active-low reset
//   time_025     0.25 s pulse shared with the select stage
//   start        select stage start flag (address 0)
//   din          select stage serial data
//   txd          UART line, idle high
//   busy         frame queued or transmitting
//   frame_valid  one-cycle pulse when a complete frame is latched
//   overrun      sticky, a frame completed while busy
// Configuration macro: EVEN_PARITY_EN selects 8E1 bytes (22*DIV per frame).
module bitstream_uart_tx
  import bitstream_uart_tx_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic clk_in,
  input  logic reset,
  input  logic time_025,
  input  logic start,
  input  logic din,
  output logic txd,
  output logic busy,
  output logic frame_valid,
  output logic overrun
);

  localparam int DIV = CLK_HZ / BAUD;

  // Edge detect mirrors the select stage; smp lands in the cycle where the
  // select stage's address has already moved on.
  logic q1_reg, q2_reg, smp_reg, adv;

  cap_state_t           cap_state_reg, cap_state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [FRAME_BITS-1:0] word, frame_word, bit_we;
  logic sample_bit, frame_done;

  logic [FRAME_BITS-1:0] frame_reg;
  logic busy_reg, byte_sel_reg, load_first_reg, frame_valid_reg, overrun_reg;
  logic last_byte, accept;
  logic tx_load, tx_last, tx_busy;
  logic [BYTE_BITS-1:0] tx_data;

  assign adv = q1_reg ^ q2_reg;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      q1_reg  <= 1'b0;
      q2_reg  <= 1'b0;
      smp_reg <= 1'b0;
    end else begin
      q1_reg  <= time_025;
      q2_reg  <= q1_reg;
      smp_reg <= adv;
    end
  end

  // ---------------- capture FSM ----------------
  assign sample_bit = smp_reg && (cap_state_reg == CAP_COLLECT) && !start;
  assign frame_done = sample_bit && (idx_reg == IDX_W'(FRAME_BITS - 1));

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cap_state_reg <= CAP_WAIT_SYNC;
      idx_reg       <= '0;
    end else begin
      cap_state_reg <= cap_state_next;
      idx_reg       <= idx_next;
    end
  end

  always_comb begin
    cap_state_next = cap_state_reg;
    idx_next       = idx_reg;
    if (smp_reg) begin
      case (cap_state_reg)
        CAP_WAIT_SYNC: begin
          if (start) begin
            cap_state_next = CAP_COLLECT;
            idx_next       = '0;
          end
        end
        CAP_COLLECT: begin
          if (start) begin
            idx_next = '0;  // resync: partial frame is abandoned
          end else if (idx_reg == IDX_W'(FRAME_BITS - 1)) begin
            cap_state_next = CAP_WAIT_SYNC;
            idx_next       = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
        default: cap_state_next = CAP_WAIT_SYNC;
      endcase
    end
  end

  // One flop per frame bit, written when its index is sampled.
  generate
    for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_word
      logic bit_reg;
      assign bit_we[gi] = sample_bit && (idx_reg == IDX_W'(gi));
      always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)          bit_reg <= 1'b0;
        else if (bit_we[gi]) bit_reg <= din;
      end
      assign word[gi] = bit_reg;
      // The final bit bypasses its flop so the frame can be handed off on
      // the completing sample itself.
      if (gi == FRAME_BITS - 1) begin : g_top
        assign frame_word[gi] = din;
      end else begin : g_low
        assign frame_word[gi] = bit_reg;
      end
    end
  endgenerate

  // ---------------- handoff and byte sequencing ----------------
  assign last_byte = (byte_sel_reg == 1'(BYTES_PER_FRAME - 1));
  // busy drops on the last stop-bit clock so a frame completing there is
  // treated as arriving at an idle transmitter.
  assign busy    = busy_reg && !(tx_last && last_byte);
  assign accept  = frame_done && !busy;
  assign tx_load = load_first_reg || (tx_last && !last_byte);
  assign tx_data = load_first_reg ? frame_reg[BYTE_BITS-1:0]
                                  : frame_reg[FRAME_BITS-1:BYTE_BITS];

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      frame_reg       <= '0;
      busy_reg        <= 1'b0;
      byte_sel_reg    <= 1'b0;
      load_first_reg  <= 1'b0;
      frame_valid_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      load_first_reg  <= accept;
      frame_valid_reg <= frame_done;
      if (frame_done && busy) overrun_reg <= 1'b1;
      if (accept) begin
        frame_reg    <= frame_word;
        busy_reg     <= 1'b1;
        byte_sel_reg <= 1'b0;
      end else if (tx_last) begin
        if (last_byte) begin
          busy_reg     <= 1'b0;
          byte_sel_reg <= 1'b0;
        end else begin
          byte_sel_reg <= byte_sel_reg + 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_tx_byte (
    .clk_in (clk_in),
    .reset  (reset),
    .load   (tx_load),
    .data   (tx_data),
    .busy   (tx_busy),
    .last   (tx_last),
    .txd    (txd)
  );

  assign frame_valid = frame_valid_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_bitstream_uart_tx.sv
// tb_bitstream_uart_tx
// Directed/randomized bench for bitstream_uart_tx at CLK_HZ=16, BAUD=1 (DIV=16).
// A UART receiver model decodes txd into bytes; the expected byte stream is
// built from the frames the bench sends.
module tb_bitstream_uart_tx;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int DIV    = 16;

  logic clk_in = 1'b0;
  logic reset = 1'b0;
  logic time_025 = 1'b0;
  logic start = 1'b0;
  logic din = 1'b0;
  logic txd, busy, frame_valid, overrun;

  always #5 clk_in = ~clk_in;

  bitstream_uart_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .time_025    (time_025),
    .start       (start),
    .din         (din),
    .txd         (txd),
    .busy        (busy),
    .frame_valid (frame_valid),
    .overrun     (overrun)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  int cyc = 0;
  int fv_cnt = 0;
  int fv_cycle = -100;
  logic fv_busy = 1'b0, fv_txd = 1'b0, fv_txd_next = 1'b0;
  int busy_run = 0;
  int busy_len = 0;
  int stop_err = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_byte;
  bit aborted;

  // frame_valid / busy observation
  always @(negedge clk_in) begin
    cyc++;
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      fv_cycle = cyc;
      fv_busy = busy;
      fv_txd = txd;
    end
    if (cyc == fv_cycle + 1) fv_txd_next = txd;
    if (busy === 1'b1) begin
      busy_run++;
    end else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  // UART 8N1 receiver, mid-bit sampling; reset aborts a byte in progress
  always begin
    @(negedge clk_in);
    if (reset === 1'b1 && txd === 1'b0) begin
      aborted = 1'b0;
      rx_byte = '0;
      for (int k = 0; k < DIV / 2; k++) begin
        @(negedge clk_in);
        if (reset !== 1'b1) aborted = 1'b1;
      end
      for (int b = 0; b < 8; b++) begin
        for (int k = 0; k < DIV; k++) begin
          @(negedge clk_in);
          if (reset !== 1'b1) aborted = 1'b1;
        end
        rx_byte[b] = txd;
      end
      for (int k = 0; k < DIV; k++) begin
        @(negedge clk_in);
        if (reset !== 1'b1) aborted = 1'b1;
      end
      if (!aborted) begin
        if (txd !== 1'b1) stop_err++;
        rx_q.push_back(rx_byte);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // One select-stage advance: drive start/din and toggle time_025.
  task automatic send_step(input bit s, input bit d);
    start = s;
    din = d;
    time_025 = ~time_025;
    repeat ($urandom_range(6, 3)) @(negedge clk_in);
  endtask

  // 1-clock pulse on time_025: two advances with the same start/din.
  task automatic send_pulse(input bit s, input bit d);
    start = s;
    din = d;
    time_025 = ~time_025;
    @(negedge clk_in);
    time_025 = ~time_025;
    repeat ($urandom_range(6, 3)) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [15:0] w);
    send_step(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send_step(1'b0, w[i]);
  endtask

  task automatic expect_frame(input logic [15:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk_in);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    end
    $display("%s: expected %0d bytes, received %0d", tag, exp_q.size(), rx_q.size());
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] w;
    int fv0, target;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);

    // Frame capture 0xA53C
    fv0 = fv_cnt;
    send_frame(16'hA53C);
    expect_frame(16'hA53C);
    wait_idle("a53c");
    chk("a53c_fv_count", fv_cnt - fv0, 1);
    chk("a53c_busy_at_fv", {31'd0, fv_busy}, 32'd1);
    chk("a53c_txd_at_fv", {31'd0, fv_txd}, 32'd1);
    chk("a53c_start_bit", {31'd0, fv_txd_next}, 32'd0);
    chk("a53c_busy_len", busy_len, 20 * DIV);
    chk("a53c_overrun", {31'd0, overrun}, 32'd0);
    check_bytes("a53c");

    // Resync: start at idx=7, then full 0x1234
    fv0 = fv_cnt;
    send_step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_step(1'b0, 1'($urandom));
    send_frame(16'h1234);
    expect_frame(16'h1234);
    wait_idle("resync");
    chk("resync_fv_count", fv_cnt - fv0, 1);
    check_bytes("resync");

    // Edge symmetry: a 1-clock pulse yields two samples
    w = 16'($urandom);
    w[8] = w[7];
    send_step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_step(1'b0, w[i]);
    send_pulse(1'b0, w[7]);
    for (int i = 9; i < 16; i++) send_step(1'b0, w[i]);
    expect_frame(w);
    wait_idle("pulse");
    check_bytes("pulse");

    // Random frames with ignored samples before sync
    for (int f = 0; f < 4; f++) begin
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) send_step(1'b0, 1'($urandom));
      w = 16'($urandom);
      send_frame(w);
      expect_frame(w);
      wait_idle("rand");
      chk("rand_busy_len", busy_len, 20 * DIV);
      check_bytes($sformatf("rand%0d_%04h", f, w));
    end
    chk("pre_overrun", {31'd0, overrun}, 32'd0);

    // Overrun: second frame completes while the first is on the wire
    w = 16'($urandom);
    send_frame(w);
    expect_frame(w);
    send_frame(~w);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    wait_idle("ovr");
    chk("ovr_busy_len", busy_len, 20 * DIV);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    check_bytes("ovr");

    // Reset during DATA bit 3 of the first byte
    w = 16'($urandom);
    send_frame(w);
    target = fv_cycle + 1 + DIV + 3 * DIV + DIV / 2;
    while (cyc < target) @(negedge clk_in);
    start = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk_in);
    repeat (3) @(negedge clk_in);
    rx_q.delete();
    exp_q.delete();
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    fv0 = fv_cnt;
    send_frame(16'h00FF);
    expect_frame(16'h00FF);
    wait_idle("post_rst");
    chk("post_rst_fv_count", fv_cnt - fv0, 1);
    chk("post_rst_overrun", {31'd0, overrun}, 32'd0);
    check_bytes("post_rst");

    chk("stop_bits", stop_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
